// File: rtl/tone_detector.sv
// Buzzer tone detector: measures the period between rising edges of tone_in
// and locks onto one of four nominal tones after CONFIRM consecutive matches.
module tone_detector #(
  parameter int CW      = 18,
  parameter int P0      = 36000,
  parameter int P1      = 15000,
  parameter int P2      = 69000,
  parameter int P3      = 102000,
  parameter int TOL     = 300,
  parameter int CONFIRM = 3,
  parameter int TIMEOUT = 150000
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          tone_in,
  output logic [1:0]    tone_id,
  output logic          tone_valid,
  output logic          new_tone,
  output logic [CW-1:0] period
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MEASURE = 2'd1;
  localparam logic [1:0] S_LOCKED  = 2'd2;

  localparam int             RW      = $clog2(CONFIRM + 1);
  localparam logic [RW-1:0]  RUN_MAX = RW'(CONFIRM);
  localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    r_state;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_syncDly;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_period;
  logic [RW-1:0] r_run;
  logic [1:0]    r_cand;
  logic [1:0]    r_toneId;
  logic          r_valid;
  logic          r_newTone;

  logic          w_edge;
  logic [CW-1:0] w_capPeriod;
  logic          w_match;
  logic [1:0]    w_matchId;
  logic [RW-1:0] w_runNext;
  logic [1:0]    w_candNext;
  logic          w_lock;

  function automatic logic inWindow(input int p, input int nom);
    return (p >= nom - TOL) && (p <= nom + TOL);
  endfunction

  assign w_edge      = r_sync2 & ~r_syncDly;
  assign w_capPeriod = r_count + 1'b1;

  // Lowest tone index wins when tolerance windows overlap.
  always_comb begin
    w_match   = 1'b1;
    w_matchId = 2'd0;
    if (inWindow(int'(w_capPeriod), P0)) begin
      w_matchId = 2'd0;
    end else if (inWindow(int'(w_capPeriod), P1)) begin
      w_matchId = 2'd1;
    end else if (inWindow(int'(w_capPeriod), P2)) begin
      w_matchId = 2'd2;
    end else if (inWindow(int'(w_capPeriod), P3)) begin
      w_matchId = 2'd3;
    end else begin
      w_match = 1'b0;
    end
  end

  always_comb begin
    w_runNext  = r_run;
    w_candNext = r_cand;
    if (!w_match) begin
      w_runNext = '0;
    end else if (w_matchId == r_cand) begin
      if (r_run != RUN_MAX) begin
        w_runNext = r_run + 1'b1;
      end
    end else begin
      w_candNext = w_matchId;
      w_runNext  = RW'(1);
    end
    w_lock = (w_runNext == RUN_MAX);
  end

  // An edge on the last count before TIMEOUT still counts as a capture.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_syncDly <= 1'b0;
      r_count   <= '0;
      r_period  <= '0;
      r_run     <= '0;
      r_cand    <= 2'd0;
      r_toneId  <= 2'd0;
      r_valid   <= 1'b0;
      r_newTone <= 1'b0;
    end else begin
      r_sync1   <= tone_in;
      r_sync2   <= r_sync1;
      r_syncDly <= r_sync2;
      r_newTone <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_count <= '0;
          if (w_edge) begin
            r_state <= S_MEASURE;
          end
        end
        default: begin
          if (w_edge) begin
            r_count  <= '0;
            r_period <= w_capPeriod;
            r_run    <= w_runNext;
            r_cand   <= w_candNext;
            if (w_lock) begin
              r_state   <= S_LOCKED;
              r_valid   <= 1'b1;
              r_toneId  <= w_candNext;
              r_newTone <= !r_valid || (r_toneId != w_candNext);
            end else begin
              r_state <= S_MEASURE;
              r_valid <= 1'b0;
            end
          end else if (r_count == TO_LAST) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_run   <= '0;
            r_count <= '0;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
      endcase
    end
  end

  assign tone_id    = r_toneId;
  assign tone_valid = r_valid;
  assign new_tone   = r_newTone;
  assign period     = r_period;

endmodule

// File: doc/tone_detector.md
TONE_DETECTOR -- requirements
Module: tone_detector

Interface
REQ-001 Parameter CW, default 18: width of the period counter and the period output.
REQ-002 Parameter P0, default 36000: nominal period of tone 0 in clk cycles (333 Hz at 12 MHz).
REQ-003 Parameter P1, default 15000: nominal period of tone 1 (800 Hz).
REQ-004 Parameter P2, default 69000: nominal period of tone 2 (174 Hz).
REQ-005 Parameter P3, default 102000: nominal period of tone 3 (117.6 Hz).
REQ-006 Parameter TOL, default 300: accepted deviation in cycles, inclusive.
REQ-007 Parameter CONFIRM, default 3: number of consecutive matching periods required to lock.
REQ-008 Parameter TIMEOUT, default 150000: number of cycles without an edge before the block declares silence; SHALL be less than 2^CW.
REQ-009 Port clk, input, 1 bit: system clock, 12 MHz; all logic is on the rising edge.
REQ-010 Port rstn, input, 1 bit: synchronous, active-low reset.
REQ-011 Port tone_in, input, 1 bit: asynchronous square wave (buzzer line).
REQ-012 Port tone_id, output, 2 bits: index of the locked tone.
REQ-013 Port tone_valid, output, 1 bit: high while a tone is locked.
REQ-014 Port new_tone, output, 1 bit: one-cycle pulse on lock or on a change of the locked tone.
REQ-015 Port period, output, CW bits: last captured period in clk cycles.

Function
REQ-016 tone_in SHALL pass through a 2-FF synchronizer; a rising edge is detected when the synchronized value is 1 and its one-cycle-delayed copy is 0 (3-cycle latency from tone_in).
REQ-017 The FSM SHALL have the states IDLE, MEASURE and LOCKED.
REQ-018 In IDLE, the counter is held at 0; the first detected edge moves the FSM to MEASURE and captures no period.
REQ-019 In MEASURE and LOCKED, the counter SHALL increment every cycle; on a detected edge, period <= counter+1 and the counter restarts at 0, so period equals the number of clk cycles between consecutive edges.
REQ-020 Classification: a captured period matches tone k if |period-Pk| <= TOL (both bounds inclusive); when windows overlap, the lowest k wins; no match is a miss.
REQ-021 On a match equal to the candidate register, run SHALL increment and saturate at CONFIRM; on a match that differs, candidate <= k and run <= 1; on a miss, run <= 0.
REQ-022 When run reaches CONFIRM, the FSM SHALL enter LOCKED with tone_valid=1 and tone_id=candidate.
REQ-023 Any capture that leaves run < CONFIRM SHALL deassert tone_valid in the next cycle and return the FSM to MEASURE; tone_id holds its last value.
REQ-024 new_tone SHALL pulse for exactly one cycle, registered with the transition of tone_valid 0->1; a continuing lock on the same tone produces no further pulses.
REQ-025 Timeout: when the counter reaches TIMEOUT with no edge, the block SHALL go to IDLE with tone_valid=0, run=0 and counter=0; period retains its value.
REQ-026 An edge that coincides with the counter reaching TIMEOUT SHALL be treated as an edge, not as a timeout.
REQ-027 The counter SHALL never wrap; it is bounded by TIMEOUT.

Reset
REQ-028 When rstn=0 at a clk edge, the block SHALL reset: FSM=IDLE; tone_id, tone_valid, new_tone, period, counter, run, candidate and the synchronizer flops all 0.
REQ-029 Reset SHALL take priority over every other event, including during LOCKED; the first edge after release is treated as a start edge.

Verification
REQ-030 Square wave with period 36000 -> after the start edge plus 3 periods: tone_valid=1, tone_id=0, one new_tone pulse, period=36000.
REQ-031 Periods of 15300 and then 15301 -> the first matches tone 1 (boundary), the second is a miss that drops tone_valid; 14700 also matches.
REQ-032 Locked on tone 0, input switches to period 102000 -> tone_valid falls after the first new period, then rises with tone_id=3 and one new_tone pulse after 3 periods.
REQ-033 Locked tone, input held static -> tone_valid falls at 150000 cycles after the last edge, the FSM is in IDLE, and period is unchanged.
REQ-034 rstn pulsed low for one cycle while locked -> all outputs 0 next cycle, and relock takes the start edge plus 3 periods.
REQ-035 Period of 50000 (out of band), repeated -> tone_valid never asserts and new_tone never pulses.
